// File: rtl/sc_mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// sc_mux_arbiter_if
// Bus bundle between the requesters / 10:1 data mux and the arbiter.
//   sc_mux_arbiter_request_InBUS [9:0] : bit i set = requester i wants the mux
//   sc_mux_arbiter_select_OutBUS [3:0] : binary index of the granted requester
//   sc_mux_arbiter_grant_OutBUS  [9:0] : one-hot grant, zero when nobody owns it
//   sc_mux_arbiter_valid_Out           : high while select drives the mux
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sc_mux_arbiter_if;
  logic [9:0] sc_mux_arbiter_request_InBUS;
  logic [3:0] sc_mux_arbiter_select_OutBUS;
  logic [9:0] sc_mux_arbiter_grant_OutBUS;
  logic       sc_mux_arbiter_valid_Out;

  modport master (
    output sc_mux_arbiter_request_InBUS,
    input  sc_mux_arbiter_select_OutBUS,
    input  sc_mux_arbiter_grant_OutBUS,
    input  sc_mux_arbiter_valid_Out
  );

  modport slave (
    input  sc_mux_arbiter_request_InBUS,
    output sc_mux_arbiter_select_OutBUS,
    output sc_mux_arbiter_grant_OutBUS,
    output sc_mux_arbiter_valid_Out
  );
endinterface

// File: rtl/sc_mux_arbiter.sv
// -----------------------------------------------------------------------------
// sc_mux_arbiter
// Round-robin arbiter owning the select of a 10:1 data mux. A requester keeps
// the grant for at most HOLD_CYCLES consecutive cycles, or until it drops its
// request; the next owner is then picked in the same cycle so there is no idle
// bubble between back-to-back owners. All outputs are registered.
// Ports:
//   sc_mux_arbiter_CLOCK_50    : clock, rising edge
//   sc_mux_arbiter_RESET_InLow : synchronous reset, active low
//   bus (slave modport)        : request in, select/grant/valid out
// -----------------------------------------------------------------------------
module sc_mux_arbiter #(
  parameter int HOLD_CYCLES = 4   // legal 1..15
) (
  input  logic            sc_mux_arbiter_CLOCK_50,
  input  logic            sc_mux_arbiter_RESET_InLow,
  sc_mux_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LP_HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_ptr;
  logic [3:0] r_cnt;
  logic [3:0] r_owner;
  logic [3:0] r_select;
  logic [9:0] r_grant;
  logic       r_valid;

  logic [9:0] w_req;
  logic [3:0] w_rel_ptr;
  logic [3:0] w_start;
  logic       w_release;
  logic [4:0] w_pick;     // {found, index}

  // First asserted request scanning start, start+1, ... wrapping 9 -> 0.
  // Iterating from the far end lets the closest hit overwrite the result.
  function automatic logic [4:0] rr_pick(input logic [9:0] req, input logic [3:0] start);
    logic [4:0] res;
    logic [4:0] sum;
    logic [3:0] idx;
    res = 5'd0;
    for (int k = 9; k >= 0; k--) begin
      sum = {1'b0, start} + 5'(k);
      if (sum >= 5'd10) begin
        idx = 4'(sum - 5'd10);
      end else begin
        idx = sum[3:0];
      end
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_req = bus.sc_mux_arbiter_request_InBUS;

  // Release detection and the scan start for the next arbitration.
  always_comb begin
    w_rel_ptr = (r_owner == 4'd9) ? 4'd0 : (r_owner + 4'd1);
    if (r_state == ST_GRANT) begin
      w_release = ~w_req[r_owner] | (r_cnt == LP_HOLD_LAST);
      // On release the pointer moves past the owner before re-arbitrating.
      w_start   = w_rel_ptr;
    end else begin
      w_release = 1'b0;
      w_start   = r_ptr;
    end
    w_pick = rr_pick(w_req, w_start);
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge sc_mux_arbiter_CLOCK_50) begin
    if (!sc_mux_arbiter_RESET_InLow) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 4'd0;
      r_cnt    <= 4'd0;
      r_owner  <= 4'd0;
      r_select <= 4'd0;
      r_grant  <= 10'd0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick[4]) begin
            r_state  <= ST_GRANT;
            r_owner  <= w_pick[3:0];
            r_select <= w_pick[3:0];
            r_grant  <= 10'd1 << w_pick[3:0];
            r_valid  <= 1'b1;
            r_cnt    <= 4'd0;
          end else begin
            // select intentionally keeps its last value while idle
            r_grant  <= 10'd0;
            r_valid  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_ptr <= w_rel_ptr;
            r_cnt <= 4'd0;
            if (w_pick[4]) begin
              r_owner  <= w_pick[3:0];
              r_select <= w_pick[3:0];
              r_grant  <= 10'd1 << w_pick[3:0];
              r_valid  <= 1'b1;
            end else begin
              r_state  <= ST_IDLE;
              r_grant  <= 10'd0;
              r_valid  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 10'd0;
          r_valid <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.sc_mux_arbiter_select_OutBUS = r_select;
  assign bus.sc_mux_arbiter_grant_OutBUS  = r_grant;
  assign bus.sc_mux_arbiter_valid_Out     = r_valid;

endmodule

// File: tb/tb_sc_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sc_mux_arbiter
// Drives two arbiters (HOLD_CYCLES 4 and 1) with the same requests. A
// behavioural reference model predicts each cycle's outputs; predictions are
// queued when stimulus is driven and popped after the following rising edge.
// Directed checks cover reset, wrap, sole requester, idle return and reset
// mid-grant; a random phase follows.
// -----------------------------------------------------------------------------
module tb_sc_mux_arbiter;

  typedef struct {
    bit         busy;
    int         ptr;
    int         cnt;
    int         owner;
    int         sel;
    logic [9:0] grant;
    bit         valid;
  } model_t;

  logic clk;
  logic rst_n;

  sc_mux_arbiter_if u_if_a ();
  sc_mux_arbiter_if u_if_b ();

  sc_mux_arbiter #(.HOLD_CYCLES(4)) u_dut_a (
    .sc_mux_arbiter_CLOCK_50    (clk),
    .sc_mux_arbiter_RESET_InLow (rst_n),
    .bus                        (u_if_a)
  );

  sc_mux_arbiter #(.HOLD_CYCLES(1)) u_dut_b (
    .sc_mux_arbiter_CLOCK_50    (clk),
    .sc_mux_arbiter_RESET_InLow (rst_n),
    .bus                        (u_if_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  model_t      m_a;
  model_t      m_b;
  logic [14:0] q_a[$];
  logic [14:0] q_b[$];

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic model_t model_next(model_t m, int hold, logic [9:0] req, logic rstn);
    model_t n;
    bit     rearb;
    int     start;
    n = m;
    if (!rstn) begin
      n.busy = 0; n.ptr = 0; n.cnt = 0; n.owner = 0; n.sel = 0;
      n.grant = 10'd0; n.valid = 0;
      return n;
    end
    rearb = !m.busy;
    start = m.ptr;
    if (m.busy) begin
      if (!req[m.owner] || m.cnt == hold - 1) begin
        rearb = 1;
        n.ptr = (m.owner + 1) % 10;
        start = n.ptr;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    if (rearb) begin
      n.busy = 0; n.valid = 0; n.grant = 10'd0; n.cnt = 0;
      for (int k = 0; k < 10; k++) begin
        if (!n.busy && req[(start + k) % 10]) begin
          n.busy  = 1;
          n.owner = (start + k) % 10;
          n.sel   = n.owner;
          n.grant = 10'd1 << n.owner;
          n.valid = 1;
        end
      end
    end
    return n;
  endfunction

  // One clock cycle: drive at negedge, predict, sample 1 ns after posedge.
  task automatic step(input logic [9:0] req, input logic rstn);
    logic [14:0] exp_v;
    logic [14:0] act_v;
    @(negedge clk);
    u_if_a.sc_mux_arbiter_request_InBUS = req;
    u_if_b.sc_mux_arbiter_request_InBUS = req;
    rst_n = rstn;
    m_a = model_next(m_a, 4, req, rstn);
    m_b = model_next(m_b, 1, req, rstn);
    q_a.push_back({4'(m_a.sel), m_a.grant, m_a.valid});
    q_b.push_back({4'(m_b.sel), m_b.grant, m_b.valid});
    @(posedge clk);
    #1;
    exp_v = q_a.pop_front();
    act_v = {u_if_a.sc_mux_arbiter_select_OutBUS, u_if_a.sc_mux_arbiter_grant_OutBUS,
             u_if_a.sc_mux_arbiter_valid_Out};
    chk("sb_hold4{sel,gnt,vld}", 32'(act_v), 32'(exp_v));
    exp_v = q_b.pop_front();
    act_v = {u_if_b.sc_mux_arbiter_select_OutBUS, u_if_b.sc_mux_arbiter_grant_OutBUS,
             u_if_b.sc_mux_arbiter_valid_Out};
    chk("sb_hold1{sel,gnt,vld}", 32'(act_v), 32'(exp_v));
  endtask

  task automatic chk_a(input string tag, input logic [3:0] sel, input logic [9:0] gnt,
                       input logic vld);
    chk({tag, "_sel"}, 32'(u_if_a.sc_mux_arbiter_select_OutBUS), 32'(sel));
    chk({tag, "_gnt"}, 32'(u_if_a.sc_mux_arbiter_grant_OutBUS),  32'(gnt));
    chk({tag, "_vld"}, 32'(u_if_a.sc_mux_arbiter_valid_Out),     32'(vld));
  endtask

  initial begin
    logic [9:0] r;
    rst_n = 1'b0;
    u_if_a.sc_mux_arbiter_request_InBUS = 10'd0;
    u_if_b.sc_mux_arbiter_request_InBUS = 10'd0;

    // Reset with every requester active: outputs stay at reset values.
    step(10'h3FF, 1'b0);
    step(10'h3FF, 1'b0);
    chk_a("reset", 4'd0, 10'd0, 1'b0);

    // Round-robin under full load: 0 x4, 1 x4, ... 9 x4, then 0 again.
    for (int i = 0; i < 41; i++) begin
      step(10'h3FF, 1'b1);
      chk(
        "rr_sel", 32'(u_if_a.sc_mux_arbiter_select_OutBUS), 32'((i / 4) % 10));
      chk("rr_vld", 32'(u_if_a.sc_mux_arbiter_valid_Out), 32'd1);
      // With HOLD 1 the grant rotates every cycle.
      chk("rot_sel", 32'(u_if_b.sc_mux_arbiter_select_OutBUS), 32'(i % 10));
    end

    // Early release and wrap: owner 9 drops, bits 0 and 8 remain.
    step(10'h000, 1'b0);
    step(10'h200, 1'b1);
    chk_a("own9", 4'd9, 10'h200, 1'b1);
    step(10'h200, 1'b1);
    step(10'b0100000001, 1'b1);
    chk_a("wrap", 4'd0, 10'h001, 1'b1);

    // Sole requester 3 for 10 cycles: valid never drops.
    step(10'h000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(10'h008, 1'b1);
      chk_a("sole3", 4'd3, 10'h008, 1'b1);
    end

    // Idle return: owner 5 drops, select holds 5; re-request has 1-cycle latency.
    step(10'h000, 1'b0);
    step(10'h020, 1'b1);
    step(10'h020, 1'b1);
    step(10'h000, 1'b1);
    chk_a("idle5", 4'd5, 10'h000, 1'b0);
    step(10'h020, 1'b1);
    chk_a("regrant5", 4'd5, 10'h020, 1'b1);

    // Reset mid-grant: move ptr off 0, grant 7 to cnt 2, pulse reset.
    step(10'h000, 1'b0);
    step(10'h004, 1'b1);
    step(10'h000, 1'b1);   // owner 2 releases, ptr -> 3
    step(10'h081, 1'b1);   // scan from 3 picks 7, not 0
    chk_a("own7", 4'd7, 10'h080, 1'b1);
    step(10'h081, 1'b1);
    step(10'h081, 1'b1);   // cnt 2
    step(10'h3FF, 1'b0);
    chk_a("rst_mid", 4'd0, 10'd0, 1'b0);
    step(10'h3FF, 1'b1);
    chk_a("ptr0", 4'd0, 10'h001, 1'b1);

    // Random traffic with occasional resets; scoreboard only.
    for (int i = 0; i < 400; i++) begin
      r = 10'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        r = r & 10'($urandom);
      end else begin
        r = r;
      end
      step(r, ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_mux_arbiter.md
SC_MUX_ARBITER -- requirements
Module: sc_mux_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, maximum consecutive cycles one requester keeps the grant; legal range 1..15.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 sc_mux_arbiter_CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 sc_mux_arbiter_RESET_InLow  input  1  synchronous reset, active-low.
REQ-005 sc_mux_arbiter_request_InBUS  input  10  bit i = requester i wants the 10:1 data mux; i = 0..9 maps to mux data inputs 1..10.
REQ-006 sc_mux_arbiter_select_OutBUS  output  4  registered mux select, binary index 0..9 of the granted requester.
REQ-007 sc_mux_arbiter_grant_OutBUS  output  10  registered one-hot grant; all zero when no grant.
REQ-008 sc_mux_arbiter_valid_Out  output  1  high while a grant is active, meaning select drives the mux.

Function
REQ-009 All outputs SHALL be registered; no combinational path from request to any output.
REQ-010 Two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-011 Internal state: search pointer ptr (4 bits, 0..9), hold counter cnt (4 bits), current owner index.
REQ-012 Arbitration SHALL be round-robin: pick the first asserted request scanning ptr, ptr+1, ... 9, 0, ... ptr-1.
REQ-013 IDLE: request_InBUS == 0 -> stay IDLE, valid 0, grant 0, select holds its last value.
REQ-014 IDLE: any request in cycle N -> GRANT from edge ending cycle N; grant/select/valid visible in cycle N+1 (1-cycle latency); cnt = 0.
REQ-015 GRANT: cnt increments by 1 each cycle while the grant is held.
REQ-016 Release condition: owner's request bit low, or cnt == HOLD_CYCLES-1.
REQ-017 On release, ptr SHALL become owner+1, wrapping 9 -> 0.
REQ-018 On release with any request asserted (owner included), the next owner SHALL be arbitrated in the same cycle from the updated ptr; the new grant appears next cycle with no idle bubble; cnt = 0.
REQ-019 On release with no request asserted -> IDLE next cycle; valid 0, grant 0.
REQ-020 A sole persistent requester SHALL be re-granted back-to-back; its valid stays continuously high while cnt restarts every HOLD_CYCLES cycles.
REQ-021 HOLD_CYCLES = 1 SHALL rotate the grant every cycle among the active requesters.
REQ-022 Requests from non-owners during GRANT SHALL NOT preempt the owner.
REQ-023 Invariants: grant one-hot or zero; grant == 0 iff valid == 0; in GRANT, select == index of the grant bit.

Reset
REQ-024 With RESET_InLow low at a rising edge, next cycle: state IDLE, ptr 0, cnt 0, select 4'b0000, grant 10'b0, valid 0.
REQ-025 Reset SHALL override everything, including mid-grant; requests sampled during reset are ignored.
REQ-026 The first arbitration after reset SHALL start from requester 0.

Verification
REQ-027 Reset: request all ones, RESET_InLow low 2 cycles -> valid 0, grant 0, select 0; first grant after release goes to requester 0.
REQ-028 Round-robin: HOLD_CYCLES 4, request 10'h3FF constant -> select 0,0,0,0,1,1,1,1,...,9,9,9,9,0; valid never drops.
REQ-029 Early release and wrap: owner 9, request 10'b0100000001 (bits 0 and 8), owner 9 drops -> next cycle select 0, grant 10'b0000000001.
REQ-030 Sole requester: request bit 3 only, held 10 cycles, HOLD 4 -> select 3 and valid 1 from cycle 2 onward, continuously; cnt restarts every 4 cycles.
REQ-031 Idle return: owner 5 is the only requester and drops bit 5 -> next cycle valid 0, grant 0, select stays 5; re-request of bit 5 -> grant 5 after 1-cycle latency.
REQ-032 Reset mid-grant: owner 7 at cnt 2, RESET_InLow pulsed low 1 cycle -> next cycle all outputs at reset values; ptr back to 0.
